csa_resolve: RTL

- Carry-save resolver: takes the redundant (sum, carry) pair produced by the team's carry-save compressor trees and converts it to a binary result, out = s + (c << 1).
- Segmented, pipelined carry-propagate adder. One SEG-bit slice is resolved per stage, and the carry ripples stage to stage through registers.
- Sits at the tail of multiplier and MAC datapaths, after the compressor tree and before writeback.
- Uses a valid/ready handshake with full backpressure.

---
 rtl/csa_resolve.sv | 110 +++++++++++
 1 files changed

// File: rtl/csa_resolve.sv
// Segmented, pipelined carry-propagate resolver: out = s + 2*c, one SEG-bit slice per stage.
// Optional 2-entry output skid FIFO enabled by defining CSA_RESOLVE_SKID_EN.
module csa_resolve #(
  parameter int DW  = 32,
  parameter int SEG = 8
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] s,
  input  logic [DW-1:0] c,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW+1:0] out
);

  localparam int W  = DW + 2;
  localparam int NS = (W + SEG - 1) / SEG;
  localparam int PW = NS * SEG;

  logic [PW-1:0] sx, cx;
  logic [PW-1:0] a_q   [NS];
  logic [PW-1:0] b_q   [NS];
  logic [PW-1:0] a_src [NS];
  logic [PW-1:0] b_src [NS];
  logic [PW-1:0] a_d   [NS];
  logic [NS-1:0] v_q, cy_q, cy_d, cin;
  logic [SEG:0]  sum;
  logic          en;

  // Vectors are padded to NS*SEG bits so every slice is full width; pad bits stay zero.
  assign sx = PW'({2'b00, s});
  assign cx = PW'({1'b0, c, 1'b0});

  always_comb begin
    a_src[0] = sx;
    b_src[0] = cx;
    for (int unsigned k = 1; k < NS; k++) begin
      a_src[k] = a_q[k-1];
      b_src[k] = b_q[k-1];
    end
    cin  = cy_q << 1;
    cy_d = '0;
    sum  = '0;
    for (int unsigned k = 0; k < NS; k++) begin
      sum = {1'b0, a_src[k][k*SEG +: SEG]} + {1'b0, b_src[k][k*SEG +: SEG]}
          + {{SEG{1'b0}}, cin[k]};
      a_d[k] = a_src[k];
      a_d[k][k*SEG +: SEG] = sum[SEG-1:0];
      if (k != NS - 1) cy_d[k] = sum[SEG];
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      v_q  <= '0;
      cy_q <= '0;
      for (int unsigned k = 0; k < NS; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
      end
    end else if (en) begin
      v_q[0] <= in_valid;
      for (int unsigned k = 1; k < NS; k++) v_q[k] <= v_q[k-1];
      cy_q <= cy_d;
      for (int unsigned k = 0; k < NS; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_src[k];
      end
    end
  end

`ifdef CSA_RESOLVE_SKID_EN
  logic [W-1:0] mem [2];
  logic [1:0]   occ;
  logic         rp, wp, push, pop;

  // Advance depends only on FIFO occupancy, so in_ready never sees out_ready combinationally.
  assign en        = (occ != 2'd2);
  assign push      = en & v_q[NS-1];
  assign pop       = out_valid & out_ready;
  assign out_valid = (occ != 2'd0);
  assign out       = mem[rp];

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      occ    <= '0;
      rp     <= 1'b0;
      wp     <= 1'b0;
    end else begin
      if (push) begin
        mem[wp] <= a_q[NS-1][W-1:0];
        wp      <= ~wp;
      end
      if (pop) rp <= ~rp;
      occ <= occ + {1'b0, push} - {1'b0, pop};
    end
  end
`else
  assign en        = ~v_q[NS-1] | out_ready;
  assign out_valid = v_q[NS-1];
  assign out       = a_q[NS-1][W-1:0];
`endif

  assign in_ready = en;

endmodule
